mx_block_quantizer: RTL and testbench

MX_BLOCK_QUANTIZER -- requirements
Module: mx_block_quantizer

---
 rtl/mx_block_quantizer.sv | 139 +++++++++++++
 tb/tb_mx_block_quantizer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_block_quantizer.sv
// MX block quantizer: gathers k signed elements, finds the shared exponent shift
// that fits the widest element into MAN_WIDTH+1 bits, and emits the block with its scale.
module mx_block_quantizer #(
  parameter int k           = 2,
  parameter int IN_WIDTH    = 16,
  parameter int MAN_WIDTH   = 7,
  parameter int scale_width = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic [scale_width-1:0]      in_scale,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [MAN_WIDTH:0]   out_mant [k],
  output logic [scale_width-1:0]      out_scale,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int CNT_W = (k > 1) ? $clog2(k) : 1;
  localparam int LEN_W = $clog2(IN_WIDTH + 1);
  localparam int SUM_W = scale_width + 1;

  typedef enum logic [1:0] {COLLECT, CALC, SEND} state_t;

  state_t                      state_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic signed [IN_WIDTH-1:0]  data_reg [k];
  logic [scale_width-1:0]      scale_reg;
  logic                        in_ready_reg;
  logic                        out_valid_reg;
  logic                        out_ovf_reg;
  logic [scale_width-1:0]      out_scale_reg;
  logic signed [MAN_WIDTH:0]   out_mant_reg [k];

  logic [IN_WIDTH-1:0]         mag [k];
  logic [IN_WIDTH-1:0]         mag_or;
  logic [LEN_W-1:0]            lmax_next;
  logic [LEN_W-1:0]            shift_next;
  logic signed [MAN_WIDTH:0]   mant_next [k];
  logic [SUM_W-1:0]            sum_next;
  logic                        accept;
  logic                        last_elem;

  assign accept    = in_valid & in_ready_reg & ~i_rst;
  assign last_elem = (cnt_reg == CNT_W'(k - 1));

  // Negative values are measured through their one's complement, so -2^n needs n bits.
  generate
    for (genvar gi = 0; gi < k; gi++) begin : g_elem
      logic signed [IN_WIDTH-1:0] shifted;
      assign mag[gi]       = data_reg[gi][IN_WIDTH-1] ? ~data_reg[gi] : data_reg[gi];
      assign shifted       = data_reg[gi] >>> shift_next;
      assign mant_next[gi] = shifted[MAN_WIDTH:0];
    end
  endgenerate

  // The bit length of the OR of all magnitudes equals the largest per-element bit length.
  always_comb begin
    mag_or = '0;
    for (int i = 0; i < k; i++) begin
      mag_or = mag_or | mag[i];
    end
    lmax_next = '0;
    for (int b = 0; b < IN_WIDTH; b++) begin
      if (mag_or[b]) lmax_next = LEN_W'(b + 1);
    end
    shift_next = (lmax_next > LEN_W'(MAN_WIDTH)) ? (lmax_next - LEN_W'(MAN_WIDTH)) : '0;
    sum_next   = SUM_W'(scale_reg) + SUM_W'(shift_next);
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      data_reg[cnt_reg] <= in_data;
      if (cnt_reg == '0) scale_reg <= in_scale;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_scale_reg <= '0;
      out_ovf_reg   <= 1'b0;
      for (int i = 0; i < k; i++) out_mant_reg[i] <= '0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            if (last_elem) begin
              cnt_reg      <= '0;
              in_ready_reg <= 1'b0;
              state_reg    <= CALC;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        CALC: begin
          for (int i = 0; i < k; i++) out_mant_reg[i] <= mant_next[i];
          // Carry out of the scale sum means the exponent cannot be represented.
          if (sum_next[scale_width]) begin
            out_scale_reg <= '1;
            out_ovf_reg   <= 1'b1;
          end else begin
            out_scale_reg <= sum_next[scale_width-1:0];
            out_ovf_reg   <= 1'b0;
          end
          out_valid_reg <= 1'b1;
          state_reg     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= COLLECT;
          end
        end
        default: begin
          state_reg     <= COLLECT;
          cnt_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_scale = out_scale_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_mant  = out_mant_reg;

endmodule

// File: tb/tb_mx_block_quantizer.sv
// Self-checking bench for mx_block_quantizer: directed cases, backpressure, resets,
// input gaps, back-to-back throughput and randomized blocks against an arithmetic model.
module tb_mx_block_quantizer;

  localparam int K  = 2;
  localparam int IW = 16;
  localparam int MW = 7;
  localparam int SW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [IW-1:0] in_data;
  logic [SW-1:0]        in_scale;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [MW:0]   out_mant [K];
  logic [SW-1:0]        out_scale;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mx_block_quantizer #(.k(K), .IN_WIDTH(IW), .MAN_WIDTH(MW), .scale_width(SW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .in_data  (in_data),
    .in_scale (in_scale),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_mant (out_mant),
    .out_scale(out_scale),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Reference: bit lengths by repeated halving, floor division by a power of two.
  function automatic void model(input int x[K], input int sc,
                                output int m[K], output int osc, output int ovf);
    int lmax, shift, p, sum;
    lmax = 0;
    for (int i = 0; i < K; i++) begin
      int v, l;
      v = (x[i] >= 0) ? x[i] : -x[i] - 1;
      l = 0;
      while (v > 0) begin
        l++;
        v = v / 2;
      end
      if (l > lmax) lmax = l;
    end
    shift = (lmax > MW) ? lmax - MW : 0;
    p = 1 << shift;
    for (int i = 0; i < K; i++)
      m[i] = (x[i] >= 0) ? x[i] / p : -((-x[i] + p - 1) / p);
    sum = sc + shift;
    if (sum > (1 << SW) - 1) begin
      osc = (1 << SW) - 1;
      ovf = 1;
    end else begin
      osc = sum;
      ovf = 0;
    end
  endfunction

  task automatic drive_elem(input int d, input int sc);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_timeout got %b want 1", in_ready);
    end
    in_data  = d[IW-1:0];
    in_scale = sc[SW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Returns number of edges from the last accept until out_valid is seen.
  task automatic get_block(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL out_valid_timeout got %b want 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'sd123; in_scale = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_scale !== 8'd0 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b vld=%b sc=%0d ovf=%b want 1 0 0 0",
               in_ready, out_valid, out_scale, out_ovf);
    end
    for (int i = 0; i < K; i++) begin
      vectors++;
      if (out_mant[i] !== '0) begin
        miscompares++;
        $display("FAIL reset_mant[%0d] got %0d want 0", i, out_mant[i]);
      end
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    int xa[3] = '{100, 1000, -32768};
    int xb[3] = '{-50, -3, 0};
    int sc[3] = '{10, 10, 250};
    int ea[3] = '{100, 125, -128};
    int eb[3] = '{-50, -1, 0};
    int es[3] = '{10, 13, 255};
    int eo[3] = '{0, 0, 1};
    int lat;
    logic signed [MW:0] e0, e1;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive_elem(xa[t], sc[t]);
      drive_elem(xb[t], sc[t]);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL directed%0d_calc got vld=%b rdy=%b want 0 0", t, out_valid, in_ready);
      end
      get_block(lat);
      e0 = ea[t][MW:0];
      e1 = eb[t][MW:0];
      vectors++;
      if (lat !== 1) begin
        miscompares++;
        $display("FAIL directed%0d_latency got %0d want 1 edge after accept", t, lat);
      end
      vectors++;
      if (out_mant[0] !== e0 || out_mant[1] !== e1) begin
        miscompares++;
        $display("FAIL directed%0d_mant got {%0d,%0d} want {%0d,%0d}", t,
                 out_mant[0], out_mant[1], ea[t], eb[t]);
      end
      vectors++;
      if (out_scale !== es[t][SW-1:0] || out_ovf !== eo[t][0]) begin
        miscompares++;
        $display("FAIL directed%0d_scale got %0d/%b want %0d/%0d", t, out_scale, out_ovf, es[t], eo[t]);
      end
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL directed%0d_handshake got rdy=%b vld=%b want 1 0", t, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int x[K];
    int m[K];
    int osc, ovf, lat;
    x[0] = 2047; x[1] = -900;
    model(x, 77, m, osc, ovf);
    out_ready = 1'b0;
    drive_elem(x[0], 77);
    drive_elem(x[1], 3);
    get_block(lat);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mant[0] !== m[0][MW:0] ||
          out_mant[1] !== m[1][MW:0] || out_scale !== osc[SW-1:0] || out_ovf !== ovf[0]) begin
        miscompares++;
        $display("FAIL hold%0d got vld=%b rdy=%b {%0d,%0d} sc=%0d want 1 0 {%0d,%0d} sc=%0d",
                 c, out_valid, in_ready, out_mant[0], out_mant[1], out_scale, m[0], m[1], osc);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    drive_elem(7, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_elem(1, 20);
    drive_elem(2, 20);
    get_block(lat);
    vectors++;
    if (out_mant[0] !== 8'sd1 || out_mant[1] !== 8'sd2 || out_scale !== 8'd20 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_collect got {%0d,%0d} sc=%0d ovf=%b want {1,2} sc=20 ovf=0",
               out_mant[0], out_mant[1], out_scale, out_ovf);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_elem(55, 3);
    drive_elem(66, 3);
    get_block(lat);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_send got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_send_quiet got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    int lat;
    out_ready = 1'b1;
    drive_elem(3000, 5);
    in_scale = 8'd200; in_data = 16'sd31000;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_stall got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    drive_elem(-7, 99);
    get_block(lat);
    vectors++;
    if (out_mant[0] !== 8'sd93 || out_mant[1] !== -8'sd1 || out_scale !== 8'd10 || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_block got {%0d,%0d} sc=%0d ovf=%b want {93,-1} sc=10 ovf=0",
               out_mant[0], out_mant[1], out_scale, out_ovf);
    end
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_single_block got vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int x[K];
    int m[K];
    int scq[$];
    int osc, ovf, blocks;
    blocks = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3 * (K + 2); c++) begin
      vectors++;
      if (in_ready !== ((c % (K + 2)) < K) || out_valid !== ((c % (K + 2)) == K + 1)) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d got rdy=%b vld=%b", c, in_ready, out_valid);
      end
      if (out_valid === 1'b1 && q.size() >= K) begin
        for (int i = 0; i < K; i++) x[i] = q.pop_front();
        model(x, scq.pop_front(), m, osc, ovf);
        blocks++;
        vectors++;
        if (out_mant[0] !== m[0][MW:0] || out_mant[1] !== m[1][MW:0] || out_scale !== osc[SW-1:0]) begin
          miscompares++;
          $display("FAIL b2b_block%0d got {%0d,%0d} sc=%0d want {%0d,%0d} sc=%0d", blocks,
                   out_mant[0], out_mant[1], out_scale, m[0], m[1], osc);
        end
      end
      in_data  = 16'(c * 1237 - 5000);
      in_scale = 8'(c * 11);
      in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        if (q.size() % K == 0) scq.push_back(c * 11);
        q.push_back(c * 1237 - 5000);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (blocks != 3) begin
      miscompares++;
      $display("FAIL b2b_count got %0d want 3", blocks);
    end
  endtask

  task automatic test_random();
    int x[K];
    int m[K];
    int osc, ovf, lat, sc, w, rdy;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < K; i++) begin
        w = $urandom_range(0, 15);
        x[i] = -(1 << w) + int'($urandom_range(0, (1 << (w + 1)) - 1));
      end
      sc  = $urandom_range(0, 255);
      rdy = $urandom_range(0, 1);
      out_ready = rdy[0];
      model(x, sc, m, osc, ovf);
      for (int i = 0; i < K; i++) begin
        repeat ($urandom_range(0, 2)) begin
          in_data = 16'($urandom); in_scale = 8'($urandom);
          @(posedge clk); #1;
        end
        drive_elem(x[i], (i == 0) ? sc : int'($urandom_range(0, 255)));
      end
      get_block(lat);
      vectors++;
      if (lat !== 1 || out_mant[0] !== m[0][MW:0] || out_mant[1] !== m[1][MW:0] ||
          out_scale !== osc[SW-1:0] || out_ovf !== ovf[0]) begin
        miscompares++;
        $display("FAIL rand%0d x={%0d,%0d} sc=%0d got lat=%0d {%0d,%0d} %0d/%b want lat=1 {%0d,%0d} %0d/%0d",
                 b, x[0], x[1], sc, lat, out_mant[0], out_mant[1], out_scale, out_ovf,
                 m[0], m[1], osc, ovf);
      end
      if (rdy == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rand%0d_handshake got rdy=%b vld=%b want 1 0", b, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_scale = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
